// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state encoding for the register file / scoreboard block.
package regfile_pkg;

    localparam int BITS_DEF = 16;
    localparam int NREG_DEF = 16;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: index -> data/busy mux, with optional write-through bypass of live writes.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int BITS   = BITS_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int RBITS  = $clog2(NREG),
    parameter bit BYPASS = 1'b1
) (
    input  logic                      ready_i,
    input  logic [RBITS-1:0]          sel_i,
    input  logic [NREG-1:0][BITS-1:0] regs_i,
    input  logic [NREG-1:0]           busy_i,
    input  logic                      alu_live_i,
    input  logic [RBITS-1:0]          alu_rd_i,
    input  logic [BITS-1:0]           alu_din_i,
    input  logic                      lw_live_i,
    input  logic [RBITS-1:0]          lw_rd_i,
    input  logic [BITS-1:0]           lw_din_i,
    output logic [BITS-1:0]           dout_o,
    output logic                      busy_o
);

    logic alu_hit, lw_hit;

    // Live-write flags already exclude index 0, so r0 can never be bypassed.
    assign alu_hit = BYPASS && alu_live_i && (alu_rd_i == sel_i);
    assign lw_hit  = BYPASS && lw_live_i  && (lw_rd_i  == sel_i);

    always_comb begin
        dout_o = '0;
        if (ready_i && (sel_i != '0)) begin
            if (alu_hit)     dout_o = alu_din_i;
            else if (lw_hit) dout_o = lw_din_i;
            else             dout_o = regs_i[sel_i];
        end
    end

    assign busy_o = ready_i && busy_i[sel_i];

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR file with ALU + load-writeback ports, busy scoreboard and post-reset clear sweep.
// Optional debug read port enabled by defining DEBUG_PORT_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int RBITS = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr_req,
    output logic             ready,
    input  logic             we,
    input  logic [RBITS-1:0] rd,
    input  logic [BITS-1:0]  rd_din,
    input  logic             lw_we,
    input  logic [RBITS-1:0] lw_rd,
    input  logic [BITS-1:0]  lw_din,
    input  logic             mark_we,
    input  logic [RBITS-1:0] mark_rd,
    input  logic [RBITS-1:0] rs1,
    input  logic [RBITS-1:0] rs2,
    output logic [BITS-1:0]  rs1_dout,
    output logic [BITS-1:0]  rs2_dout,
    output logic             rs1_busy,
    output logic             rs2_busy
`ifdef DEBUG_PORT_EN
    ,
    input  logic [RBITS-1:0] dbg_sel,
    output logic [BITS-1:0]  dbg_dout
`endif
);

    rf_state_e                 state_q;
    logic [RBITS-1:0]          idx_q;
    logic                      ready_q;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [NREG-1:0][BITS-1:0] regs_q;

    logic active, alu_live, lw_live, mark_live;

    assign active    = (state_q == READY) && run;
    assign alu_live  = active && we      && (rd      != '0);
    assign lw_live   = active && lw_we   && (lw_rd   != '0);
    assign mark_live = active && mark_we && (mark_rd != '0);

    // Set after clear so a same-cycle mark wins over the load completion.
    always_comb begin
        busy_d = busy_q;
        if (lw_live)   busy_d[lw_rd]   = 1'b0;
        if (mark_live) busy_d[mark_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= RBITS'(1);
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    idx_q <= idx_q + RBITS'(1);
                    if (idx_q == RBITS'(NREG - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state_q <= INIT;
                        ready_q <= 1'b0;
                        idx_q   <= RBITS'(1);
                        busy_q  <= '0;
                    end else begin
                        busy_q  <= busy_d;
                    end
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                    idx_q   <= RBITS'(1);
                    busy_q  <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep clears it. ALU write is applied last so it wins.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            regs_q[idx_q] <= '0;
        end else begin
            if (lw_live)  regs_q[lw_rd] <= lw_din;
            if (alu_live) regs_q[rd]    <= rd_din;
        end
        regs_q[0] <= '0;
    end

    assign ready = ready_q;

    regfile_read_port #(.BITS(BITS), .NREG(NREG), .RBITS(RBITS), .BYPASS(1'b1)) u_rp1 (
        .ready_i    (ready_q),
        .sel_i      (rs1),
        .regs_i     (regs_q),
        .busy_i     (busy_q),
        .alu_live_i (alu_live),
        .alu_rd_i   (rd),
        .alu_din_i  (rd_din),
        .lw_live_i  (lw_live),
        .lw_rd_i    (lw_rd),
        .lw_din_i   (lw_din),
        .dout_o     (rs1_dout),
        .busy_o     (rs1_busy)
    );

    regfile_read_port #(.BITS(BITS), .NREG(NREG), .RBITS(RBITS), .BYPASS(1'b1)) u_rp2 (
        .ready_i    (ready_q),
        .sel_i      (rs2),
        .regs_i     (regs_q),
        .busy_i     (busy_q),
        .alu_live_i (alu_live),
        .alu_rd_i   (rd),
        .alu_din_i  (rd_din),
        .lw_live_i  (lw_live),
        .lw_rd_i    (lw_rd),
        .lw_din_i   (lw_din),
        .dout_o     (rs2_dout),
        .busy_o     (rs2_busy)
    );

`ifdef DEBUG_PORT_EN
    logic dbg_busy_unused;

    regfile_read_port #(.BITS(BITS), .NREG(NREG), .RBITS(RBITS), .BYPASS(1'b0)) u_rpdbg (
        .ready_i    (ready_q),
        .sel_i      (dbg_sel),
        .regs_i     (regs_q),
        .busy_i     (busy_q),
        .alu_live_i (alu_live),
        .alu_rd_i   (rd),
        .alu_din_i  (rd_din),
        .lw_live_i  (lw_live),
        .lw_rd_i    (lw_rd),
        .lw_din_i   (lw_din),
        .dout_o     (dbg_dout),
        .busy_o     (dbg_busy_unused)
    );
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default build, no debug port).
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst, run, clr_req, ready;
    logic        we, lw_we, mark_we;
    logic [3:0]  rd, lw_rd, mark_rd, rs1, rs2;
    logic [15:0] rd_din, lw_din, rs1_dout, rs2_dout;
    logic        rs1_busy, rs2_busy;

    int n_chk = 0;
    int n_err = 0;
    int cnt;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clr_req  (clr_req),
        .ready    (ready),
        .we       (we),
        .rd       (rd),
        .rd_din   (rd_din),
        .lw_we    (lw_we),
        .lw_rd    (lw_rd),
        .lw_din   (lw_din),
        .mark_we  (mark_we),
        .mark_rd  (mark_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_dout (rs1_dout),
        .rs2_dout (rs2_dout),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; lw_we = 0; mark_we = 0; clr_req = 0;
        rd = 0; lw_rd = 0; mark_rd = 0;
        rd_din = 0; lw_din = 0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst = 1; run = 1; rs1 = 0; rs2 = 0;
        idle();

        // 1: reset and initial sweep
        repeat (3) step();
        rs1 = 4'd5;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_rs1_dout", rs1_dout, 0);
        chk("rst_rs1_busy", rs1_busy, 0);
        rst = 0;
        wait_ready(cnt);
        chk("init_cycles", cnt, 15);
        for (int i = 1; i < 16; i++) begin
            rs1 = 4'(i);
            #1;
            chk($sformatf("swept_r%0d", i), rs1_dout, 0);
        end

        // 2: bypass then stored value
        we = 1; rd = 4'd5; rd_din = 16'hBEEF; rs1 = 4'd5;
        #1 chk("bypass_alu", rs1_dout, 16'hBEEF);
        step();
        idle();
        #1 chk("stored_r5", rs1_dout, 16'hBEEF);

        // 3: ALU beats load on same index; r0 stays zero
        we = 1; rd = 4'd3; rd_din = 16'h1111;
        lw_we = 1; lw_rd = 4'd3; lw_din = 16'h2222; rs1 = 4'd3;
        #1 chk("bypass_prio", rs1_dout, 16'h1111);
        step();
        idle();
        #1 chk("stored_r3", rs1_dout, 16'h1111);
        we = 1; rd = 4'd0; rd_din = 16'hFFFF; rs2 = 4'd0;
        #1 chk("r0_bypass", rs2_dout, 0);
        step();
        idle();
        #1 chk("r0_stored", rs2_dout, 0);

        // 4: scoreboard set / set-wins / clear
        mark_we = 1; mark_rd = 4'd7; rs1 = 4'd7;
        #1 chk("busy_not_yet", rs1_busy, 0);
        step();
        idle();
        #1 chk("busy_set", rs1_busy, 1);
        lw_we = 1; lw_rd = 4'd7; lw_din = 16'hAAAA; mark_we = 1; mark_rd = 4'd7;
        step();
        idle();
        #1 chk("busy_set_wins", rs1_busy, 1);
        chk("r7_lw_aaaa", rs1_dout, 16'hAAAA);
        lw_we = 1; lw_rd = 4'd7; lw_din = 16'h5555;
        #1 chk("bypass_lw", rs1_dout, 16'h5555);
        chk("busy_no_bypass", rs1_busy, 1);
        step();
        idle();
        #1 chk("busy_cleared", rs1_busy, 0);
        chk("r7_lw_5555", rs1_dout, 16'h5555);

        // 5: run=0 freezes everything
        run = 0;
        we = 1; rd = 4'd7; rd_din = 16'h9999; mark_we = 1; mark_rd = 4'd8;
        rs1 = 4'd7; rs2 = 4'd8;
        #1 chk("frozen_no_bypass", rs1_dout, 16'h5555);
        step();
        idle();
        #1 chk("frozen_r7", rs1_dout, 16'h5555);
        chk("frozen_busy8", rs2_busy, 0);
        run = 1;

        // 6: clear request, then reset mid-sweep
        we = 1; rd = 4'd9; rd_din = 16'h1234;
        mark_we = 1; mark_rd = 4'd10;
        step();
        idle();
        rs1 = 4'd9; rs2 = 4'd10;
        #1 chk("r9_written", rs1_dout, 16'h1234);
        chk("busy10_set", rs2_busy, 1);
        clr_req = 1;
        step();
        clr_req = 0;
        #1 chk("clr_ready", ready, 0);
        chk("clr_init_read0", rs1_dout, 0);
        chk("clr_init_busy0", rs2_busy, 0);
        wait_ready(cnt);
        chk("clr_cycles", cnt, 15);
        chk("clr_r9", rs1_dout, 0);
        chk("clr_busy10", rs2_busy, 0);

        we = 1; rd = 4'd9; rd_din = 16'h4321;
        step();
        idle();
        #1 chk("r9_rewritten", rs1_dout, 16'h4321);
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (5) step();
        rst = 1;
        step();
        rst = 0;
        wait_ready(cnt);
        chk("rst_mid_cycles", cnt, 15);
        chk("rst_mid_r9", rs1_dout, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
